// File: rtl/memory_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// memory_arbiter_pkg
// Shared types and constants for the two-requester data-memory arbiter.
//   req_id_t            : requester identifier (1 bit)
//   REQ_CORE / REQ_AUX  : core memory issue path / secondary master (debug/DMA)
//   count_width()       : width of an occupancy counter for a given depth
// -----------------------------------------------------------------------------
package memory_arbiter_pkg;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_CORE = 1'b0;
    localparam req_id_t REQ_AUX  = 1'b1;

    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int COUNT_WIDTH_DEFAULT = count_width(MAX_OUTSTANDING_DEFAULT);

endpackage : memory_arbiter_pkg

// File: rtl/memory_arbiter_id_fifo.sv
// -----------------------------------------------------------------------------
// arb_id_fifo
// In-order FIFO of requester IDs for reads in flight. The head is read straight
// from registered storage so response routing needs no extra cycle.
//   clock, reset (async active-low)
//   push, push_id : enqueue the ID of a granted read (ignored when full)
//   pop           : dequeue on a read response (ignored when empty)
//   full, empty, count, head
// -----------------------------------------------------------------------------
module arb_id_fifo
    import memory_arbiter_pkg::*;
#(
    parameter int DEPTH       = MAX_OUTSTANDING_DEFAULT,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  req_id_t                push_id,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] count,
    output req_id_t                head
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    req_id_t                id_mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr_reg;
    logic [PTR_WIDTH-1:0]   rd_ptr_reg;
    logic [COUNT_WIDTH-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == COUNT_WIDTH'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    assign head    = id_mem[rd_ptr_reg];

    // Storage carries no reset; stale entries are never observed because
    // the pointers and count are cleared.
    always_ff @(posedge clock) begin
        if (do_push) begin
            id_mem[wr_ptr_reg] <= push_id;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + COUNT_WIDTH'(1);
                2'b01:   count_reg <= count_reg - COUNT_WIDTH'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule : arb_id_fifo

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
// Shares one data-memory port between requester 0 (core memory issue path) and
// requester 1 (debug/DMA). Round-robin on conflict, zero-latency forwarding of
// the winner's request, and in-order routing of read responses back to the
// requester that issued each read.
//
// Ports
//   clock, reset (async assert, active-low)
//   rN_read/rN_write/rN_byte_en/rN_address/rN_data : request from requester N
//   rN_grant                                       : request accepted this cycle
//   rN_valid/rN_read_data                          : read response to requester N
//   memory_read/write/byte_en/address/data         : forwarded request
//   memory_ready                                   : memory accepts a request
//   memory_valid/memory_read_data                  : in-order read response
//   protocol_error                                 : sticky, response with no read outstanding
//   scan                                           : trace enable
//
// Build option: define MEMORY_ARBITER_SCAN_EN to compile in a cycle counter and
// a per-cycle trace gated by scan and [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX].
// -----------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 20,
    parameter int NUM_BYTES       = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
    parameter int CORE            = 0,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic                    r0_read,
    input  logic                    r0_write,
    input  logic [NUM_BYTES-1:0]    r0_byte_en,
    input  logic [ADDRESS_BITS-1:0] r0_address,
    input  logic [DATA_WIDTH-1:0]   r0_data,
    output logic                    r0_grant,
    output logic                    r0_valid,
    output logic [DATA_WIDTH-1:0]   r0_read_data,

    input  logic                    r1_read,
    input  logic                    r1_write,
    input  logic [NUM_BYTES-1:0]    r1_byte_en,
    input  logic [ADDRESS_BITS-1:0] r1_address,
    input  logic [DATA_WIDTH-1:0]   r1_data,
    output logic                    r1_grant,
    output logic                    r1_valid,
    output logic [DATA_WIDTH-1:0]   r1_read_data,

    output logic                    memory_read,
    output logic                    memory_write,
    output logic [NUM_BYTES-1:0]    memory_byte_en,
    output logic [ADDRESS_BITS-1:0] memory_address,
    output logic [DATA_WIDTH-1:0]   memory_data,
    input  logic                    memory_ready,
    input  logic                    memory_valid,
    input  logic [DATA_WIDTH-1:0]   memory_read_data,

    output logic                    protocol_error,
    input  logic                    scan
);

    localparam int COUNT_WIDTH = count_width(MAX_OUTSTANDING);

    req_id_t                last_grant_reg;
    logic                   protocol_error_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [COUNT_WIDTH-1:0] fifo_count;
    req_id_t                fifo_head;

    logic                   eligible_0;
    logic                   eligible_1;
    logic                   grant_any;
    req_id_t                winner;
    logic                   push;
    logic                   pop;
    logic                   stray_response;

    // A full FIFO blocks reads even if a response pops in the same cycle:
    // eligibility looks only at registered occupancy. The reset term forces
    // every combinational output low while reset is held.
    assign eligible_0 = reset && memory_ready && (r0_write || (r0_read && !fifo_full));
    assign eligible_1 = reset && memory_ready && (r1_write || (r1_read && !fifo_full));
    assign grant_any  = eligible_0 || eligible_1;

    always_comb begin
        winner = REQ_CORE;
        if (eligible_0 && eligible_1) begin
            winner = (last_grant_reg == REQ_CORE) ? REQ_AUX : REQ_CORE;
        end else if (eligible_1) begin
            winner = REQ_AUX;
        end
    end

    assign r0_grant = grant_any && (winner == REQ_CORE);
    assign r1_grant = grant_any && (winner == REQ_AUX);

    always_comb begin
        memory_read    = 1'b0;
        memory_write   = 1'b0;
        memory_byte_en = '0;
        memory_address = '0;
        memory_data    = '0;
        if (r0_grant) begin
            memory_read    = r0_read;
            memory_write   = r0_write;
            memory_byte_en = r0_byte_en;
            memory_address = r0_address;
            memory_data    = r0_data;
        end else if (r1_grant) begin
            memory_read    = r1_read;
            memory_write   = r1_write;
            memory_byte_en = r1_byte_en;
            memory_address = r1_address;
            memory_data    = r1_data;
        end
    end

    assign push           = memory_read;
    assign pop            = reset && memory_valid && !fifo_empty;
    assign stray_response = reset && memory_valid && fifo_empty;

    assign r0_valid     = pop && (fifo_head == REQ_CORE);
    assign r1_valid     = pop && (fifo_head == REQ_AUX);
    assign r0_read_data = r0_valid ? memory_read_data : '0;
    assign r1_read_data = r1_valid ? memory_read_data : '0;

    assign protocol_error = protocol_error_reg;

    // Reset value REQ_AUX makes requester 0 win the first conflict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_reg     <= REQ_AUX;
            protocol_error_reg <= 1'b0;
        end else begin
            if (grant_any) begin
                last_grant_reg <= winner;
            end
            if (stray_response) begin
                protocol_error_reg <= 1'b1;
            end
        end
    end

    arb_id_fifo #(
        .DEPTH       (MAX_OUTSTANDING),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .head    (fifo_head)
    );

`ifdef MEMORY_ARBITER_SCAN_EN
    logic [31:0] cycle_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
        end
    end

    always @(posedge clock) begin
        if (reset && scan &&
            cycle_count_reg >= 32'(SCAN_CYCLES_MIN) &&
            cycle_count_reg <= 32'(SCAN_CYCLES_MAX)) begin
            $display("core %0d cycle %0d grant=%b%b rd=%b wr=%b be=%h addr=%h data=%h count=%0d head=%0d resp=%b%b rdata=%h",
                     CORE, cycle_count_reg, r1_grant, r0_grant,
                     memory_read, memory_write, memory_byte_en,
                     memory_address, memory_data, fifo_count, fifo_head,
                     r1_valid, r0_valid, memory_read_data);
        end
    end
`else
    localparam int unused_scan_cfg = CORE + SCAN_CYCLES_MIN + SCAN_CYCLES_MAX;
    logic unused_scan;
    assign unused_scan = &{1'b0, scan, fifo_count};
`endif

endmodule : memory_arbiter

// File: tb/tb_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_memory_arbiter
// Directed vectors for memory_arbiter. Requester 0 always presents address
// 0x00010 / byte_en 0xF / data 0xA0A0A0A0, requester 1 presents 0x00020 /
// 0x3 / 0xB0B0B0B0, so the forwarded bus is implied by which grant is expected.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        r0_read, r0_write, r1_read, r1_write;
    logic [3:0]  r0_byte_en, r1_byte_en;
    logic [19:0] r0_address, r1_address;
    logic [31:0] r0_data, r1_data;
    logic        r0_grant, r0_valid, r1_grant, r1_valid;
    logic [31:0] r0_read_data, r1_read_data;
    logic        memory_read, memory_write;
    logic [3:0]  memory_byte_en;
    logic [19:0] memory_address;
    logic [31:0] memory_data;
    logic        memory_ready, memory_valid;
    logic [31:0] memory_read_data;
    logic        protocol_error;
    logic        scan;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    memory_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .r0_read          (r0_read),
        .r0_write         (r0_write),
        .r0_byte_en       (r0_byte_en),
        .r0_address       (r0_address),
        .r0_data          (r0_data),
        .r0_grant         (r0_grant),
        .r0_valid         (r0_valid),
        .r0_read_data     (r0_read_data),
        .r1_read          (r1_read),
        .r1_write         (r1_write),
        .r1_byte_en       (r1_byte_en),
        .r1_address       (r1_address),
        .r1_data          (r1_data),
        .r1_grant         (r1_grant),
        .r1_valid         (r1_valid),
        .r1_read_data     (r1_read_data),
        .memory_read      (memory_read),
        .memory_write     (memory_write),
        .memory_byte_en   (memory_byte_en),
        .memory_address   (memory_address),
        .memory_data      (memory_data),
        .memory_ready     (memory_ready),
        .memory_valid     (memory_valid),
        .memory_read_data (memory_read_data),
        .protocol_error   (protocol_error),
        .scan             (scan)
    );

    typedef struct {
        string       name;
        logic        r0_rd, r0_wr, r1_rd, r1_wr, rdy, mv;
        logic [31:0] md;
        logic        g0, g1, mrd, mwr, v0, v1, perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name,
                                input logic r0_rd, r0_wr, r1_rd, r1_wr, rdy, mv,
                                input logic [31:0] md,
                                input logic g0, g1, mrd, mwr, v0, v1, perr);
        vec_t v;
        v.name = name;
        v.r0_rd = r0_rd; v.r0_wr = r0_wr; v.r1_rd = r1_rd; v.r1_wr = r1_wr;
        v.rdy = rdy; v.mv = mv; v.md = md;
        v.g0 = g0; v.g1 = g1; v.mrd = mrd; v.mwr = mwr;
        v.v0 = v0; v.v1 = v1; v.perr = perr;
        return v;
    endfunction

    // Expected observable vector: {pad, g0, g1, rd, wr, addr, be, data, v0, v1, rd0, rd1, perr}
    function automatic logic [127:0] expect_vec(input vec_t v);
        logic [19:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        addr = v.g0 ? 20'h00010 : (v.g1 ? 20'h00020 : 20'h0);
        be   = v.g0 ? 4'hF : (v.g1 ? 4'h3 : 4'h0);
        data = v.g0 ? 32'hA0A0A0A0 : (v.g1 ? 32'hB0B0B0B0 : 32'h0);
        return {1'b0, v.g0, v.g1, v.mrd, v.mwr, addr, be, data, v.v0, v.v1,
                (v.v0 ? v.md : 32'h0), (v.v1 ? v.md : 32'h0), v.perr};
    endfunction

    function automatic logic [127:0] actual_vec();
        return {1'b0, r0_grant, r1_grant, memory_read, memory_write,
                memory_address, memory_byte_en, memory_data, r0_valid, r1_valid,
                r0_read_data, r1_read_data, protocol_error};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic drive(input vec_t v);
        r0_read = v.r0_rd; r0_write = v.r0_wr;
        r1_read = v.r1_rd; r1_write = v.r1_wr;
        memory_ready = v.rdy; memory_valid = v.mv; memory_read_data = v.md;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        drive(v);
        #2;
        check(v.name, actual_vec(), expect_vec(v));
    endtask

    vec_t idle;

    initial begin
        r0_byte_en = 4'hF; r0_address = 20'h00010; r0_data = 32'hA0A0A0A0;
        r1_byte_en = 4'h3; r1_address = 20'h00020; r1_data = 32'hB0B0B0B0;
        scan = 1'b0;
        reset = 1'b0;
        idle = mk("idle", 0,0,0,0,0,0, 32'h0, 0,0,0,0,0,0,0);

        // Requests and a response while reset is held: everything stays 0.
        drive(mk("rst", 1,0,1,0,1,1, 32'h1, 0,0,0,0,0,0,0));
        #3;
        check("reset_hold", actual_vec(), 128'h0);
        repeat (2) @(negedge clock);
        drive(idle);
        reset = 1'b1;

        //                name        r0r r0w r1r r1w rdy mv md            g0 g1 rd wr v0 v1 perr
        vecs.push_back(mk("rr_c0",     1,0,1,0,1,0, 32'h0,        1,0,1,0,0,0,0));
        vecs.push_back(mk("rr_c1",     1,0,1,0,1,0, 32'h0,        0,1,1,0,0,0,0));
        vecs.push_back(mk("rr_c2",     1,0,1,0,1,1, 32'h11111111, 1,0,1,0,1,0,0));
        vecs.push_back(mk("rr_c3",     1,0,1,0,1,1, 32'h22222222, 0,1,1,0,0,1,0));
        vecs.push_back(mk("rr_rsp2",   0,0,0,0,1,1, 32'h33333333, 0,0,0,0,1,0,0));
        vecs.push_back(mk("rr_rsp3",   0,0,0,0,1,1, 32'h44444444, 0,0,0,0,0,1,0));
        vecs.push_back(mk("wr_r0",     0,1,0,0,1,0, 32'h0,        1,0,0,1,0,0,0));
        vecs.push_back(mk("wr_after",  0,0,0,0,1,0, 32'h0,        0,0,0,0,0,0,0));
        vecs.push_back(mk("fill_0",    1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,0));
        vecs.push_back(mk("fill_1",    1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,0));
        vecs.push_back(mk("fill_2",    1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,0));
        vecs.push_back(mk("fill_3",    1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,0));
        vecs.push_back(mk("full_wr",   0,1,1,0,1,0, 32'h0,        1,0,0,1,0,0,0));
        vecs.push_back(mk("full_blk",  0,0,1,0,1,0, 32'h0,        0,0,0,0,0,0,0));
        vecs.push_back(mk("full_pop",  0,0,1,0,1,1, 32'h55555555, 0,0,0,0,1,0,0));
        vecs.push_back(mk("full_gnt",  0,0,1,0,1,0, 32'h0,        0,1,1,0,0,0,0));
        vecs.push_back(mk("drain_0",   0,0,0,0,1,1, 32'h66666666, 0,0,0,0,1,0,0));
        vecs.push_back(mk("drain_1",   0,0,0,0,1,1, 32'h77777777, 0,0,0,0,1,0,0));
        vecs.push_back(mk("drain_2",   0,0,0,0,1,1, 32'h88888888, 0,0,0,0,1,0,0));
        vecs.push_back(mk("drain_3",   0,0,0,0,1,1, 32'h99999999, 0,0,0,0,0,1,0));
        vecs.push_back(mk("no_ready",  0,1,0,1,0,0, 32'h0,        0,0,0,0,0,0,0));
        vecs.push_back(mk("ready_rr",  0,1,0,1,1,0, 32'h0,        1,0,0,1,0,0,0));
        vecs.push_back(mk("stray_rsp", 0,0,0,0,1,1, 32'hDEADBEEF, 0,0,0,0,0,0,0));
        vecs.push_back(mk("perr_on",   0,0,0,0,1,0, 32'h0,        0,0,0,0,0,0,1));
        vecs.push_back(mk("perr_hold", 0,0,0,1,1,0, 32'h0,        0,1,0,1,0,0,1));
        vecs.push_back(mk("inflight0", 1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,1));
        vecs.push_back(mk("inflight1", 1,0,0,0,1,0, 32'h0,        1,0,1,0,0,0,1));

        foreach (vecs[i]) begin
            apply(vecs[i]);
        end

        // Reset with two reads in flight: outputs drop at once.
        @(negedge clock);
        drive(mk("rst_mid", 1,0,1,0,1,1, 32'h12345678, 0,0,0,0,0,0,0));
        reset = 1'b0;
        #1;
        check("reset_async", actual_vec(), 128'h0);

        // After release: r0 wins the conflict, the stale response is dropped.
        @(negedge clock);
        reset = 1'b1;
        begin
            vec_t v;
            v = mk("post_rst_conflict", 0,1,0,1,1,1, 32'hCAFEF00D, 1,0,0,1,0,0,0);
            drive(v);
            #2;
            check(v.name, actual_vec(), expect_vec(v));
            v = mk("late_rsp_err", 0,0,0,0,1,0, 32'h0, 0,0,0,0,0,0,1);
            @(negedge clock);
            drive(v);
            #2;
            check(v.name, actual_vec(), expect_vec(v));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_memory_arbiter
